tc_sram_banked_mem: RTL and testbench
=====================================

Name: tc_sram_banked_mem

Overview:
- Simulation/FPGA memory model behind the existing axi_to_mem / obi_to_mem adapters, generalising the single-port, single-bank testbench memory.
- NumPorts memory-side request ports share NumBanks word-interleaved banks. Each bank has its own round-robin arbitration, a fixed read/write response latency and optional pseudo-random stall injection.
- Used in tb top-levels to stress bus adapters with bank conflicts and backpressure.

Parameters:
- NumPorts, 2, number of independent requestor ports (>=1)
- NumBanks, 4, number of banks; power of two (>=1)
- AddrWidth, 32, byte-address width per port
- DataWidth, 64, word width in bits; multiple of 8, power of two
- WordsPerBank, 1024, rows per bank; power of two
- Latency, 1, cycles from grant to rvalid (>=1)
- StallEn, 0, 1 = enable LFSR-driven per-bank stall injection
- LfsrSeed, 16'hACE1, reset seed of bank 0 LFSR; bank b uses LfsrSeed ^ b (non-zero)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- req_i  in  NumPorts  request valid per port
- gnt_o  out  NumPorts  request accepted this cycle (combinational)
- we_i  in  NumPorts  1 = write
- addr_i  in  NumPorts x AddrWidth  byte address
- wdata_i  in  NumPorts x DataWidth  write data
- be_i  in  NumPorts x DataWidth/8  byte enables
- rvalid_o  out  NumPorts  response valid (reads and writes)
- rdata_o  out  NumPorts x DataWidth  read data; 0 when rvalid_o low
- conflict_cnt_o  out  32  saturating count of port-cycles with req_i high and gnt_o low

Behaviour:
- Address split: OffBits = log2(DataWidth/8); bank = addr[OffBits +: log2(NumBanks)]; row = next log2(WordsPerBank) bits. Upper bits are ignored (wrap-around). NumBanks=1 gives a zero-width bank field and bank 0 always.
- Arbitration per bank, each cycle: among ports with req_i high targeting bank b, grant one, searching round-robin from rr_ptr[b]. After a grant, rr_ptr[b] = winner+1 mod NumPorts. Without a grant, rr_ptr[b] is unchanged.
- At most one access per bank per cycle. Ports hitting different banks are all granted in the same cycle.
- Stall: when StallEn=1 and lfsr[b][0]=1, bank b grants nothing. Each LFSR (x^16+x^14+x^13+x^11) steps every cycle regardless of traffic. With StallEn=0 the LFSRs are absent or constant.
- Write on grant: bytes with be_i set are updated at the clock edge. be_i=0 means no change, but a response is still produced.
- Read on grant: row contents are sampled at the grant edge.
  - A write granted in cycle N is visible to a read granted in cycle N+1.
- Response: rvalid_o[p] asserts exactly Latency cycles after the gnt_o[p] cycle, for one cycle, with rdata_o. Writes return rdata_o=0.
  - Per-port shift pipeline of depth Latency carrying {valid, bank, row, we}. Read data is captured at grant and carried along the pipeline.
  - Back-to-back grants on a port produce back-to-back responses, in order.
- No rready: the requestor must always accept responses.
- conflict_cnt_o increments by popcount(req_i & ~gnt_o) per cycle and saturates at 32'hFFFF_FFFF.
- Reset (async assert, sync release):
  - gnt_o=0 while rst_i high; rvalid_o=0, rdata_o=0, conflict_cnt_o=0.
  - rr_ptr=0; LFSRs reloaded with their seeds.
  - Memory contents are NOT cleared; the tb preloads by hierarchical write.
  - Reset mid-operation drops all in-flight responses, and no rvalid_o appears afterward for them.
- A request held while not granted must keep addr/we/wdata/be stable (requestor rule). A violation is flagged by an assertion in simulation.

Decomposition:
- Package tc_sram_banked_pkg: address-split functions (bank_idx, row_idx), response pipeline struct typedef, LFSR polynomial/step function, saturating-add width constant.
- Sub-module tc_sram_bank_arb, one instance per bank:
  - inputs: per-port request-hits-bank vector and stall;
  - outputs: one-hot grant and winner index;
  - holds its own rr_ptr.
- Top module holds the storage arrays, the response pipelines and the counter.

Test Plan:
- Latency=1, one port. Write 64'hDEAD_BEEF_0123_4567 to 0x08 with be=8'hFF, then read 0x08 next cycle: gnt same cycle, rvalid 1 cycle later, rdata=64'hDEAD_BEEF_0123_4567.
- Partial write be=8'h0F of 64'h1111_1111_2222_2222 over 64'hFFFF_FFFF_FFFF_FFFF: read returns 64'hFFFF_FFFF_2222_2222.
- Two ports both reading bank 1 (0x08, 0x28) every cycle for 4 cycles: grants alternate p0,p1,p0,p1; conflict_cnt_o=4.
- Port 0 on 0x00 and port 1 on 0x08 (different banks): both granted every cycle; conflict_cnt_o stays 0.
- Latency=3, 5 back-to-back reads: 5 consecutive rvalid_o pulses starting 3 cycles after the first grant, in address order.
- Assert rst_i while 2 reads are in flight (Latency=3): no rvalid_o afterwards, rr_ptr and conflict_cnt_o=0. StallEn=1: the gnt_o pattern matches the LFSR reference model.

Source files
------------

// File: rtl/tc_sram_banked_mem_pkg.sv
// rtl/tc_sram_banked_mem_pkg.sv - shared types and helpers for the banked SRAM model
package tc_sram_banked_pkg;

   localparam int unsigned CntWidth = 32;
   // Taps at bits 0,2,3,5 of a right-shifting Fibonacci LFSR: x^16+x^14+x^13+x^11+1
   localparam logic [15:0] LfsrTaps = 16'h002D;

   typedef struct packed {
      logic valid;
      logic we;
   } rsp_t;

   function automatic int unsigned bank_idx(input logic [63:0] addr, input int unsigned off_bits,
                                            input int unsigned num_banks);
      return 32'((addr >> off_bits) & 64'(num_banks - 1));
   endfunction

   function automatic int unsigned row_idx(input logic [63:0] addr, input int unsigned shift,
                                           input int unsigned rows);
      return 32'((addr >> shift) & 64'(rows - 1));
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {^(s & LfsrTaps), s[15:1]};
   endfunction

   function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] a, input int unsigned b);
      logic [CntWidth:0] sum;
      sum = {1'b0, a} + (CntWidth+1)'(b);
      return sum[CntWidth] ? '1 : sum[CntWidth-1:0];
   endfunction

endpackage

// File: rtl/tc_sram_banked_mem_if.sv
// rtl/tc_sram_banked_mem_if.sv - multi-port memory request/response bus
interface tc_sram_banked_mem_if #(
   parameter int unsigned NumPorts  = 2,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 64
);
   import tc_sram_banked_pkg::*;

   logic [NumPorts-1:0]                  req_i;
   logic [NumPorts-1:0]                  gnt_o;
   logic [NumPorts-1:0]                  we_i;
   logic [NumPorts-1:0][AddrWidth-1:0]   addr_i;
   logic [NumPorts-1:0][DataWidth-1:0]   wdata_i;
   logic [NumPorts-1:0][DataWidth/8-1:0] be_i;
   logic [NumPorts-1:0]                  rvalid_o;
   logic [NumPorts-1:0][DataWidth-1:0]   rdata_o;
   logic [CntWidth-1:0]                  conflict_cnt_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i, be_i,
      input  gnt_o, rvalid_o, rdata_o, conflict_cnt_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, be_i,
      output gnt_o, rvalid_o, rdata_o, conflict_cnt_o
   );
endinterface

// File: rtl/tc_sram_banked_mem_bank_arb.sv
// rtl/tc_sram_banked_mem_bank_arb.sv - per-bank round-robin arbiter with stall input
module tc_sram_bank_arb #(
   parameter  int unsigned NumPorts = 2,
   localparam int unsigned PortW    = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NumPorts-1:0] hit,
   input  logic                stall,
   output logic [NumPorts-1:0] gnt,
   output logic [PortW-1:0]    win,
   output logic                act
);
   logic [PortW-1:0] rr_ptr;
   logic [PortW-1:0] idx;

   always_comb begin
      gnt = '0;
      win = '0;
      act = 1'b0;
      idx = '0;
      if (!stall) begin
         for (int i = 0; i < NumPorts; i++) begin
            idx = PortW'((32'(rr_ptr) + 32'(i)) % NumPorts);
            if (!act && hit[idx]) begin
               act      = 1'b1;
               win      = idx;
               gnt[idx] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (act) begin
         rr_ptr <= (win == PortW'(NumPorts - 1)) ? '0 : win + 1'b1;
      end
   end
endmodule

// File: rtl/tc_sram_banked_mem.sv
// rtl/tc_sram_banked_mem.sv - word-interleaved multi-bank SRAM model with fixed-latency responses
module tc_sram_banked_mem
   import tc_sram_banked_pkg::*;
#(
   parameter int unsigned NumPorts     = 2,
   parameter int unsigned NumBanks     = 4,
   parameter int unsigned AddrWidth    = 32,
   parameter int unsigned DataWidth    = 64,
   parameter int unsigned WordsPerBank = 1024,
   parameter int unsigned Latency      = 1,
   parameter bit          StallEn      = 1'b0,
   parameter logic [15:0] LfsrSeed     = 16'hACE1
) (
   input logic                  clk_i,
   input logic                  rst_i,
   tc_sram_banked_mem_if.slave  bus
);
   localparam int unsigned OffBits  = $clog2(DataWidth / 8);
   localparam int unsigned BankBits = $clog2(NumBanks);
   localparam int unsigned BankW    = (NumBanks > 1) ? BankBits : 1;
   localparam int unsigned RowW     = (WordsPerBank > 1) ? $clog2(WordsPerBank) : 1;
   localparam int unsigned PortW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam int unsigned BeW      = DataWidth / 8;

   logic [BankW-1:0]     port_bank  [NumPorts];
   logic [RowW-1:0]      port_row   [NumPorts];
   logic [NumPorts-1:0]  bank_gnt   [NumBanks];
   logic [PortW-1:0]     bank_win   [NumBanks];
   logic [DataWidth-1:0] bank_rdata [NumBanks];
   logic [NumBanks-1:0]  bank_act;
   logic [NumPorts-1:0]  gnt;
   logic [CntWidth-1:0]  cnt;

   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         port_bank[p] = BankW'(bank_idx(64'(bus.addr_i[p]), OffBits, NumBanks));
         port_row[p]  = RowW'(row_idx(64'(bus.addr_i[p]), OffBits + BankBits, WordsPerBank));
      end
   end

   for (genvar b = 0; b < NumBanks; b++) begin : g_bank
      logic [NumPorts-1:0]  hit;
      logic [15:0]          lfsr;
      logic                 stall;
      logic [RowW-1:0]      wrow;
      logic [DataWidth-1:0] mem [WordsPerBank];

      always_comb begin
         hit = '0;
         for (int p = 0; p < NumPorts; p++) begin
            hit[p] = bus.req_i[p] && (port_bank[p] == BankW'(b)) && !rst_i;
         end
      end

      // Without stall injection the LFSR simply holds its seed
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) lfsr <= LfsrSeed ^ 16'(b);
         else       lfsr <= StallEn ? lfsr_step(lfsr) : lfsr;
      end
      assign stall = StallEn && lfsr[0];

      tc_sram_bank_arb #(.NumPorts(NumPorts)) u_arb (
         .clk   (clk_i),
         .rst   (rst_i),
         .hit   (hit),
         .stall (stall),
         .gnt   (bank_gnt[b]),
         .win   (bank_win[b]),
         .act   (bank_act[b])
      );

      assign wrow          = port_row[bank_win[b]];
      assign bank_rdata[b] = mem[wrow];

      always_ff @(posedge clk_i) begin
         if (bank_act[b] && bus.we_i[bank_win[b]]) begin
            for (int i = 0; i < BeW; i++) begin
               if (bus.be_i[bank_win[b]][i]) mem[wrow][i*8 +: 8] <= bus.wdata_i[bank_win[b]][i*8 +: 8];
            end
         end
      end
   end

   always_comb begin
      gnt = '0;
      for (int b = 0; b < NumBanks; b++) gnt |= bank_gnt[b];
   end
   assign bus.gnt_o = gnt;

   // Read data is captured at the grant edge and travels with its pipeline slot
   for (genvar p = 0; p < NumPorts; p++) begin : g_port
      rsp_t                 pipe  [Latency];
      logic [DataWidth-1:0] pdata [Latency];

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            for (int s = 0; s < Latency; s++) begin
               pipe[s]  <= '0;
               pdata[s] <= '0;
            end
         end else begin
            pipe[0].valid <= gnt[p];
            pipe[0].we    <= bus.we_i[p];
            pdata[0]      <= gnt[p] ? bank_rdata[port_bank[p]] : '0;
            for (int s = 1; s < Latency; s++) begin
               pipe[s]  <= pipe[s-1];
               pdata[s] <= pdata[s-1];
            end
         end
      end

      assign bus.rvalid_o[p] = pipe[Latency-1].valid;
      assign bus.rdata_o[p]  = (pipe[Latency-1].valid && !pipe[Latency-1].we) ? pdata[Latency-1] : '0;

      a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
         (bus.req_i[p] && !gnt[p]) |=> (!bus.req_i[p] ||
            ($stable(bus.addr_i[p]) && $stable(bus.we_i[p]) &&
             $stable(bus.wdata_i[p]) && $stable(bus.be_i[p]))));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt <= '0;
      else       cnt <= sat_add(cnt, unsigned'($countones(bus.req_i & ~gnt)));
   end
   assign bus.conflict_cnt_o = cnt;
endmodule

// File: tb/tb_tc_sram_banked_mem.sv
// tb/tb_tc_sram_banked_mem.sv - directed and randomized checks of tc_sram_banked_mem
module tb_tc_sram_banked_mem;
   localparam int NP  = 2;
   localparam int NB  = 4;
   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int WPB = 16;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tc_sram_banked_mem_if #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW)) bus_a ();
   tc_sram_banked_mem_if #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW)) bus_b ();

   tc_sram_banked_mem #(.NumPorts(NP), .NumBanks(NB), .AddrWidth(AW), .DataWidth(DW),
      .WordsPerBank(WPB), .Latency(1), .StallEn(1'b0), .LfsrSeed(16'hACE1)) dut_a (
      .clk_i(clk), .rst_i(rst), .bus(bus_a));

   tc_sram_banked_mem #(.NumPorts(NP), .NumBanks(NB), .AddrWidth(AW), .DataWidth(DW),
      .WordsPerBank(WPB), .Latency(LAT), .StallEn(1'b1), .LfsrSeed(16'hACE1)) dut_b (
      .clk_i(clk), .rst_i(rst), .bus(bus_b));

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input int p, input logic req, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] d, input logic [7:0] be);
      bus_a.req_i[p]   = req;
      bus_a.we_i[p]    = we;
      bus_a.addr_i[p]  = addr;
      bus_a.wdata_i[p] = d;
      bus_a.be_i[p]    = be;
   endtask

   function automatic logic [63:0] pre_val(input int b, input int r);
      return {32'(b) ^ 32'h5A5A_0000, 32'(r) * 32'h9E37_79B9};
   endfunction

   function automatic int bank_of(input logic [AW-1:0] a);
      return int'((a / 8) % NB);
   endfunction

   function automatic int row_of(input logic [AW-1:0] a);
      return int'((a / (8 * NB)) % WPB);
   endfunction

   for (genvar b = 0; b < NB; b++) begin : g_pre
      initial for (int r = 0; r < WPB; r++) dut_b.g_bank[b].mem[r] = pre_val(b, r);
   end

   // Reference model for dut_b
   logic [DW-1:0]    mem_m  [NB][WPB];
   int               rr_m   [NB];
   logic [15:0]      lfsr_m [NB];
   logic             due_v  [NP][8];
   logic [DW-1:0]    due_d  [NP][8];
   logic [31:0]      cnt_m;
   logic [NP-1:0]    pend, p_we, eg;
   logic [AW-1:0]    p_addr [NP];
   logic [DW-1:0]    p_wd   [NP];
   logic [7:0]       p_be   [NP];
   logic             in_rst;
   longint           tmp;
   int               slot, bk, rw;

   initial begin
      bus_a.req_i = '0; bus_a.we_i = '0; bus_a.addr_i = '0; bus_a.wdata_i = '0; bus_a.be_i = '0;
      bus_b.req_i = '0; bus_b.we_i = '0; bus_b.addr_i = '0; bus_b.wdata_i = '0; bus_b.be_i = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_gnt", 64'(bus_a.gnt_o), 0);
      check_val("rst_rvalid", 64'(bus_a.rvalid_o), 0);
      check_val("rst_cnt", 64'(bus_a.conflict_cnt_o), 0);
      tick();
      rst = 1'b0;

      // Full write then read-back
      set_a(0, 1, 1, 32'h08, 64'hDEAD_BEEF_0123_4567, 8'hFF);
      @(negedge clk);
      check_val("wr_gnt", 64'(bus_a.gnt_o), 64'b01);
      tick();
      set_a(0, 1, 0, 32'h08, 0, 0);
      @(negedge clk);
      check_val("rd_gnt", 64'(bus_a.gnt_o), 64'b01);
      check_val("wr_rvalid", 64'(bus_a.rvalid_o), 64'b01);
      check_val("wr_rdata", bus_a.rdata_o[0], 0);
      tick();
      set_a(0, 1, 1, 32'h10, '1, 8'hFF);
      @(negedge clk);
      check_val("rd_rvalid", 64'(bus_a.rvalid_o), 64'b01);
      check_val("rd_rdata", bus_a.rdata_o[0], 64'hDEAD_BEEF_0123_4567);

      // Partial write over all-ones
      tick();
      set_a(0, 1, 1, 32'h10, 64'h1111_1111_2222_2222, 8'h0F);
      tick();
      set_a(0, 1, 0, 32'h10, 0, 0);
      tick();
      set_a(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_val("part_rdata", bus_a.rdata_o[0], 64'hFFFF_FFFF_2222_2222);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Two ports contending for bank 1
      set_a(0, 1, 0, 32'h08, 0, 0);
      set_a(1, 1, 0, 32'h28, 0, 0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_val($sformatf("conf_gnt%0d", c), 64'(bus_a.gnt_o), (c % 2 == 0) ? 64'b01 : 64'b10);
         tick();
      end
      set_a(0, 0, 0, 0, 0, 0);
      set_a(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_val("conf_cnt", 64'(bus_a.conflict_cnt_o), 4);
      tick();

      // Different banks proceed in parallel
      set_a(0, 1, 0, 32'h00, 0, 0);
      set_a(1, 1, 0, 32'h08, 0, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_val($sformatf("par_gnt%0d", c), 64'(bus_a.gnt_o), 64'b11);
         tick();
      end
      set_a(0, 0, 0, 0, 0, 0);
      set_a(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_val("par_cnt", 64'(bus_a.conflict_cnt_o), 4);

      // Randomized traffic on the stalling, Latency=3 instance
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int b = 0; b < NB; b++) begin
         rr_m[b]   = 0;
         lfsr_m[b] = 16'hACE1 ^ 16'(b);
         for (int r = 0; r < WPB; r++) mem_m[b][r] = pre_val(b, r);
      end
      for (int p = 0; p < NP; p++)
         for (int s = 0; s < 8; s++) begin
            due_v[p][s] = 1'b0;
            due_d[p][s] = '0;
         end
      cnt_m = 0;
      pend  = '0;
      p_we  = '0;

      for (int cyc = 0; cyc < 600; cyc++) begin
         in_rst = (cyc == 300) || (cyc == 301);
         rst    = in_rst;
         for (int p = 0; p < NP; p++) begin
            if (in_rst) begin
               pend[p] = 1'b0;
            end else if (!pend[p] && $urandom_range(0, 3) != 0) begin
               pend[p]   = 1'b1;
               p_we[p]   = 1'($urandom_range(0, 1));
               p_addr[p] = $urandom;
               p_wd[p]   = {$urandom, $urandom};
               p_be[p]   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            end
            bus_b.req_i[p]   = pend[p];
            bus_b.we_i[p]    = p_we[p];
            bus_b.addr_i[p]  = p_addr[p];
            bus_b.wdata_i[p] = p_wd[p];
            bus_b.be_i[p]    = p_be[p];
         end
         if (in_rst) begin
            for (int b = 0; b < NB; b++) begin
               rr_m[b]   = 0;
               lfsr_m[b] = 16'hACE1 ^ 16'(b);
            end
            for (int p = 0; p < NP; p++)
               for (int s = 0; s < 8; s++) due_v[p][s] = 1'b0;
            cnt_m = 0;
         end

         @(negedge clk);
         eg = '0;
         if (!in_rst) begin
            for (int b = 0; b < NB; b++) begin
               if (lfsr_m[b][0] == 1'b0) begin
                  for (int i = 0; i < NP; i++) begin
                     int q;
                     q = (rr_m[b] + i) % NP;
                     if (pend[q] && bank_of(p_addr[q]) == b) begin
                        eg[q]   = 1'b1;
                        rr_m[b] = (q + 1) % NP;
                        break;
                     end
                  end
               end
            end
         end

         slot = cyc % 8;
         check_val($sformatf("rnd_gnt@%0d", cyc), 64'(bus_b.gnt_o), 64'(eg));
         check_val($sformatf("rnd_cnt@%0d", cyc), 64'(bus_b.conflict_cnt_o), 64'(cnt_m));
         for (int p = 0; p < NP; p++) begin
            check_val($sformatf("rnd_rvalid%0d@%0d", p, cyc), 64'(bus_b.rvalid_o[p]), 64'(due_v[p][slot]));
            check_val($sformatf("rnd_rdata%0d@%0d", p, cyc), bus_b.rdata_o[p], due_v[p][slot] ? due_d[p][slot] : 64'h0);
            due_v[p][slot] = 1'b0;
         end

         if (!in_rst) begin
            tmp   = longint'(cnt_m) + longint'($countones(pend & ~eg));
            cnt_m = (tmp > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(tmp);
            for (int p = 0; p < NP; p++) begin
               if (eg[p]) begin
                  bk = bank_of(p_addr[p]);
                  rw = row_of(p_addr[p]);
                  due_v[p][(cyc + LAT) % 8] = 1'b1;
                  due_d[p][(cyc + LAT) % 8] = p_we[p] ? 64'h0 : mem_m[bk][rw];
               end
            end
            for (int p = 0; p < NP; p++) begin
               if (eg[p] && p_we[p]) begin
                  bk = bank_of(p_addr[p]);
                  rw = row_of(p_addr[p]);
                  for (int i = 0; i < 8; i++)
                     if (p_be[p][i]) mem_m[bk][rw][i*8 +: 8] = p_wd[p][i*8 +: 8];
               end
               if (eg[p]) pend[p] = 1'b0;
            end
            for (int b = 0; b < NB; b++) begin
               logic [15:0] fb;
               fb        = (lfsr_m[b] ^ (lfsr_m[b] >> 2) ^ (lfsr_m[b] >> 3) ^ (lfsr_m[b] >> 5)) & 16'h1;
               lfsr_m[b] = (lfsr_m[b] >> 1) | (fb << 15);
            end
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
